// File: rtl/count_sched.sv
// Round-robin arbiter and clear sequencer for the dual-channel event counter's
// single increment port, tracking the channel-1 divide-by-4 phase.
module count_sched #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [N_REQ-1:0] Req,
  input  logic [N_REQ-1:0] Sel,
  input  logic             Hold,
  input  logic             ClrReq,
  output logic [N_REQ-1:0] Grant,
  output logic             CntEn,
  output logic             CntSlt,
  output logic             CntReset,
  output logic             ClrAck,
  output logic             Ch1Tick,
  output logic             Busy
);

  typedef enum logic [1:0] {ARB, CLR, CLR_WAIT} state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [1:0]       phase;

  logic [N_REQ-1:0] eligible;
  logic             found;
  logic [PTR_W-1:0] winner;
  int               idx;

  // Last cycle's winner is masked so a requester that drops Req one edge late
  // is not granted twice.
  always_comb begin
    eligible = Req & ~Grant;
    found    = 1'b0;
    winner   = ptr;
    idx      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state    <= ARB;
      ptr      <= '0;
      phase    <= '0;
      Grant    <= '0;
      CntEn    <= 1'b0;
      CntSlt   <= 1'b0;
      CntReset <= 1'b0;
      ClrAck   <= 1'b0;
      Ch1Tick  <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      Grant    <= '0;
      CntEn    <= 1'b0;
      CntSlt   <= 1'b0;
      CntReset <= 1'b0;
      ClrAck   <= 1'b0;
      Ch1Tick  <= 1'b0;
      Busy     <= 1'b0;
      case (state)
        ARB: begin
          if (ClrReq) begin
            state    <= CLR;
            CntReset <= 1'b1;
            ClrAck   <= 1'b1;
            Busy     <= 1'b1;
          end else if (!Hold && found) begin
            Grant  <= N_REQ'(1) << winner;
            CntEn  <= 1'b1;
            CntSlt <= Sel[winner];
            Busy   <= 1'b1;
            ptr    <= PTR_W'((int'(winner) + 1) % N_REQ);
            // Phase mirrors the counter's prescaler, which a counter clear leaves intact.
            if (Sel[winner]) begin
              phase   <= phase + 2'd1;
              Ch1Tick <= (phase == 2'd3);
            end
          end
        end
        CLR: begin
          state <= CLR_WAIT;
          Busy  <= 1'b1;
        end
        CLR_WAIT: begin
          if (ClrReq) Busy  <= 1'b1;
          else        state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_count_sched.sv
// Directed bench for count_sched: outputs are compared as one packed vector
// {Grant, CntEn, CntSlt, CntReset, ClrAck, Ch1Tick, Busy} against hand-computed values.
module tb_count_sched;
  localparam int N_REQ = 4;
  localparam int PTR_W = 2;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [3:0] Req, Sel;
  logic       Hold, ClrReq;
  logic [3:0] Grant;
  logic       CntEn, CntSlt, CntReset, ClrAck, Ch1Tick, Busy;

  int errors = 0;
  int checks = 0;
  int n;

  localparam logic [9:0] IDLE = 10'b0;

  count_sched #(.N_REQ(N_REQ), .PTR_W(PTR_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .Sel(Sel), .Hold(Hold), .ClrReq(ClrReq),
    .Grant(Grant), .CntEn(CntEn), .CntSlt(CntSlt), .CntReset(CntReset),
    .ClrAck(ClrAck), .Ch1Tick(Ch1Tick), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [9:0] obs();
    return {Grant, CntEn, CntSlt, CntReset, ClrAck, Ch1Tick, Busy};
  endfunction

  function automatic logic [9:0] ev(input logic [3:0] g, input logic e, input logic s,
                                    input logic r, input logic a, input logic t, input logic b);
    return {g, e, s, r, a, t, b};
  endfunction

  initial begin
    Reset_n = 1'b0; Req = 4'b1111; Sel = 4'b0000; Hold = 1'b0; ClrReq = 1'b0;
    step(); step();
    check("reset", obs(), IDLE);

    // Round robin from requester 0 after release
    Reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rr%0d", i), obs(), ev(4'(1 << (i % 4)), 1, 0, 0, 0, 0, 1));
    end
    Req = 4'b0000; step();
    check("rr_idle", obs(), IDLE);

    // Same requester held: alternate cycles only
    Req = 4'b0100; n = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("mask%0d", i), obs(), (i % 2 == 0) ? ev(4'b0100, 1, 0, 0, 0, 0, 1) : IDLE);
      if (Grant[2]) n++;
    end
    check("mask_cnt", 10'(n), 10'd3);
    Req = 4'b0000; step();

    // Registered requester dropping Req one edge after Grant
    Req = 4'b0001; n = 0;
    step(); if (Grant[0]) n++;
    step(); if (Grant[0]) n++;
    Req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step(); if (Grant[0]) n++;
    end
    check("drop_cnt", 10'(n), 10'd1);

    // Channel-1 ticks on 4th and 8th Sel=1 grant
    Reset_n = 1'b0; step(); Reset_n = 1'b1;
    Req = 4'b0010; Sel = 4'b0010; n = 0;
    for (int i = 0; i < 18; i++) begin
      step();
      if (Grant[1]) begin
        n++;
        check($sformatf("tick_g%0d", n), obs(), ev(4'b0010, 1, 1, 0, 0, (n == 4 || n == 8), 1));
      end else begin
        check($sformatf("tick_idle%0d", i), obs(), IDLE);
      end
    end
    check("tick_cnt", 10'(n), 10'd9);

    // Sel=0 grants leave Phase at 1
    Req = 4'b0001; Sel = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("sel0_%0d", i), obs(), (i % 2 == 0) ? ev(4'b0001, 1, 0, 0, 0, 0, 1) : IDLE);
    end
    Req = 4'b0010; Sel = 4'b0010; n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (Grant[1]) begin
        n++;
        check($sformatf("phase_g%0d", n), obs(), ev(4'b0010, 1, 1, 0, 0, (n == 3), 1));
      end
    end
    check("phase_cnt", 10'(n), 10'd5);
    Req = 4'b0000; step();

    // Clear priority; Phase (now 2) survives the clear
    Req = 4'b0011; Sel = 4'b0010; ClrReq = 1'b1;
    step(); check("clr", obs(), ev(4'b0000, 0, 0, 1, 1, 0, 1));
    for (int i = 0; i < 3; i++) begin
      step(); check($sformatf("clr_wait%0d", i), obs(), ev(4'b0000, 0, 0, 0, 0, 0, 1));
    end
    ClrReq = 1'b0;
    step(); check("clr_exit", obs(), IDLE);
    step(); check("clr_g0", obs(), ev(4'b0001, 1, 0, 0, 0, 0, 1));
    step(); check("clr_g1", obs(), ev(4'b0010, 1, 1, 0, 0, 0, 1));
    step(); check("clr_g2", obs(), ev(4'b0001, 1, 0, 0, 0, 0, 1));
    step(); check("clr_g3", obs(), ev(4'b0010, 1, 1, 0, 0, 1, 1));
    Req = 4'b0000; step();

    // Hold stalls grants, pointer stays put
    Reset_n = 1'b0; step(); Reset_n = 1'b1;
    Hold = 1'b1; Req = 4'b1010; Sel = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step(); check($sformatf("hold%0d", i), obs(), IDLE);
    end
    Hold = 1'b0;
    step(); check("hold_g1", obs(), ev(4'b0010, 1, 0, 0, 0, 0, 1));
    step(); check("hold_g3", obs(), ev(4'b1000, 1, 0, 0, 0, 0, 1));
    Req = 4'b0000; step();

    // Clear is serviced while Hold is asserted
    Hold = 1'b1; Req = 4'b1010; ClrReq = 1'b1;
    step(); check("hclr", obs(), ev(4'b0000, 0, 0, 1, 1, 0, 1));
    ClrReq = 1'b0;
    step(); check("hclr_wait", obs(), ev(4'b0000, 0, 0, 0, 0, 0, 1));
    step(); check("hclr_exit", obs(), IDLE);
    step(); check("hclr_held", obs(), IDLE);

    // Reset during CLR_WAIT
    Hold = 1'b0; Req = 4'b0000; ClrReq = 1'b1;
    step(); check("mr_clr", obs(), ev(4'b0000, 0, 0, 1, 1, 0, 1));
    step(); check("mr_wait", obs(), ev(4'b0000, 0, 0, 0, 0, 0, 1));
    Reset_n = 1'b0;
    step(); check("mr_rst_wait", obs(), IDLE);
    Reset_n = 1'b1; ClrReq = 1'b0;
    step(); check("mr_after_wait", obs(), IDLE);

    // Reset during a grant cycle: Ptr and Phase back to 0
    Req = 4'b0110; Sel = 4'b0010;
    step(); check("mr_grant", obs(), ev(4'b0010, 1, 1, 0, 0, 0, 1));
    Reset_n = 1'b0;
    step(); check("mr_rst_grant", obs(), IDLE);
    Reset_n = 1'b1; Req = 4'b1111; Sel = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("mr_rr%0d", i), obs(), ev(4'(1 << i), 1, 1, 0, 0, (i == 3), 1));
    end
    Req = 4'b0000; step();
    check("final_idle", obs(), IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
